// File: rtl/sat_engine_ctrl.sv
// Top-level sequencer of one sat engine: drives decision/BCP/analysis/backtrack
// strobes, reports the per-bin solve result and keeps per-solve statistics.
module sat_engine_ctrl #(
    parameter int WIDTH_LVL    = 16,
    parameter int WIDTH_BIN_ID = 10,
    parameter int WIDTH_CNT    = 16,
    parameter int WIDTH_TO     = 8,
    parameter int TIMEOUT      = 200
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [WIDTH_BIN_ID-1:0] cur_bin_num_i,
    input  logic [WIDTH_LVL-1:0]    cur_lvl_i,
    input  logic                    all_assigned_i,
    output logic                    start_decision_o,
    input  logic                    done_decision_i,
    output logic                    apply_imply_o,
    input  logic                    done_imply_i,
    input  logic                    find_conflict_i,
    output logic                    apply_analyze_o,
    input  logic                    done_analyze_i,
    input  logic [WIDTH_BIN_ID-1:0] bkt_bin_i,
    input  logic [WIDTH_LVL-1:0]    bkt_lvl_i,
    output logic                    apply_bkt_cur_bin_o,
    input  logic                    done_bkt_cur_bin_i,
    output logic                    done_o,
    output logic [1:0]              result_o,
    output logic                    timeout_o,
    output logic [WIDTH_BIN_ID-1:0] bkt_bin_o,
    output logic [WIDTH_LVL-1:0]    bkt_lvl_o,
    output logic                    busy_o,
    output logic [WIDTH_CNT-1:0]    num_decisions_o,
    output logic [WIDTH_CNT-1:0]    num_conflicts_o
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_IMPLY    = 4'd1;
    localparam logic [3:0] S_DECIDE   = 4'd2;
    localparam logic [3:0] S_WAIT_DEC = 4'd3;
    localparam logic [3:0] S_ANALYZE  = 4'd4;
    localparam logic [3:0] S_WAIT_ANA = 4'd5;
    localparam logic [3:0] S_BKT      = 4'd6;
    localparam logic [3:0] S_WAIT_BKT = 4'd7;
    localparam logic [3:0] S_FINISH   = 4'd8;

    localparam logic [1:0] RES_NONE    = 2'd0;
    localparam logic [1:0] RES_SAT     = 2'd1;
    localparam logic [1:0] RES_UNSAT   = 2'd2;
    localparam logic [1:0] RES_BKT_OUT = 2'd3;

    localparam logic [WIDTH_TO-1:0]  WD_LAST = WIDTH_TO'(TIMEOUT - 1);
    localparam logic [WIDTH_CNT-1:0] CNT_MAX = '1;

    logic [3:0]              state_q, state_d;
    logic [WIDTH_TO-1:0]     wd_q, wd_d;
    logic [1:0]              result_q, result_d;
    logic                    timeout_q, timeout_d;
    logic [WIDTH_BIN_ID-1:0] bkt_bin_q, bkt_bin_d;
    logic [WIDTH_LVL-1:0]    bkt_lvl_q, bkt_lvl_d;
    logic [WIDTH_CNT-1:0]    dec_q, dec_d;
    logic [WIDTH_CNT-1:0]    conf_q, conf_d;
    logic                    wd_expired;
    logic                    fire_timeout;
    logic                    waiting;

    function automatic logic [WIDTH_CNT-1:0] sat_inc(input logic [WIDTH_CNT-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Expiry fires on the edge where the watchdog would reach TIMEOUT.
    assign wd_expired = (wd_q == WD_LAST);
    assign waiting    = (state_q == S_IMPLY) || (state_q == S_WAIT_DEC) ||
                        (state_q == S_WAIT_ANA) || (state_q == S_WAIT_BKT);

    always_comb begin
        state_d      = state_q;
        result_d     = result_q;
        timeout_d    = timeout_q;
        bkt_bin_d    = bkt_bin_q;
        bkt_lvl_d    = bkt_lvl_q;
        dec_d        = dec_q;
        conf_d       = conf_q;
        fire_timeout = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_IMPLY;
                    dec_d     = '0;
                    conf_d    = '0;
                    timeout_d = 1'b0;
                    result_d  = RES_NONE;
                end
            end
            S_IMPLY: begin
                if (find_conflict_i) begin
                    conf_d = sat_inc(conf_q);
                    if (cur_lvl_i == '0) begin
                        state_d  = S_FINISH;
                        result_d = RES_UNSAT;
                    end else begin
                        state_d = S_ANALYZE;
                    end
                end else if (done_imply_i) begin
                    if (all_assigned_i) begin
                        state_d  = S_FINISH;
                        result_d = RES_SAT;
                    end else begin
                        state_d = S_DECIDE;
                    end
                end else if (wd_expired) begin
                    fire_timeout = 1'b1;
                end
            end
            S_DECIDE: begin
                dec_d   = sat_inc(dec_q);
                state_d = S_WAIT_DEC;
            end
            S_WAIT_DEC: begin
                if (done_decision_i) state_d = S_IMPLY;
                else if (wd_expired) fire_timeout = 1'b1;
            end
            S_ANALYZE: state_d = S_WAIT_ANA;
            S_WAIT_ANA: begin
                if (done_analyze_i) begin
                    bkt_bin_d = bkt_bin_i;
                    bkt_lvl_d = bkt_lvl_i;
                    if (bkt_bin_i != cur_bin_num_i) begin
                        state_d  = S_FINISH;
                        result_d = RES_BKT_OUT;
                    end else begin
                        state_d = S_BKT;
                    end
                end else if (wd_expired) begin
                    fire_timeout = 1'b1;
                end
            end
            S_BKT: state_d = S_WAIT_BKT;
            S_WAIT_BKT: begin
                if (done_bkt_cur_bin_i) state_d = S_IMPLY;
                else if (wd_expired) fire_timeout = 1'b1;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (fire_timeout) begin
            state_d   = S_FINISH;
            timeout_d = 1'b1;
            result_d  = RES_NONE;
        end

        if (state_d != state_q) wd_d = '0;
        else if (waiting)       wd_d = wd_q + 1'b1;
        else                    wd_d = wd_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wd_q      <= '0;
            result_q  <= RES_NONE;
            timeout_q <= 1'b0;
            bkt_bin_q <= '0;
            bkt_lvl_q <= '0;
            dec_q     <= '0;
            conf_q    <= '0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
            bkt_bin_q <= bkt_bin_d;
            bkt_lvl_q <= bkt_lvl_d;
            dec_q     <= dec_d;
            conf_q    <= conf_d;
        end
    end

    assign apply_imply_o       = (state_q == S_IMPLY);
    assign start_decision_o    = (state_q == S_DECIDE);
    assign apply_analyze_o     = (state_q == S_ANALYZE);
    assign apply_bkt_cur_bin_o = (state_q == S_BKT);
    assign done_o              = (state_q == S_FINISH);
    assign busy_o              = (state_q != S_IDLE);
    assign result_o            = result_q;
    assign timeout_o           = timeout_q;
    assign bkt_bin_o           = bkt_bin_q;
    assign bkt_lvl_o           = bkt_lvl_q;
    assign num_decisions_o     = dec_q;
    assign num_conflicts_o     = conf_q;

endmodule

// File: tb/tb_sat_engine_ctrl.sv
// Self-checking bench for sat_engine_ctrl: scripted solves (directed and random)
// answered by a responder, checked against a per-solve outcome model.
module tb_sat_engine_ctrl;
    localparam int WL = 16;
    localparam int WB = 10;
    localparam int WC = 3;
    localparam int WT = 8;
    localparam int TO = 10;
    localparam int CMAX = (1 << WC) - 1;

    localparam int K_DEC = 0, K_LOC = 1, K_SAT = 2, K_UNSAT = 3, K_BOUT = 4, K_TMO = 5;

    typedef struct {
        int kind;
        int idle;
        int lat1;
        int lat2;
        int lvl;
        int bbin;
        int blvl;
        bit noise;
    } step_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_i = 1'b0;
    logic [WB-1:0] cur_bin_num_i = '0;
    logic [WL-1:0] cur_lvl_i = '0;
    logic          all_assigned_i = 1'b0;
    logic          done_decision_i = 1'b0;
    logic          done_imply_i = 1'b0;
    logic          find_conflict_i = 1'b0;
    logic          done_analyze_i = 1'b0;
    logic [WB-1:0] bkt_bin_i = '0;
    logic [WL-1:0] bkt_lvl_i = '0;
    logic          done_bkt_cur_bin_i = 1'b0;
    logic          start_decision_o, apply_imply_o, apply_analyze_o, apply_bkt_cur_bin_o;
    logic          done_o, timeout_o, busy_o;
    logic [1:0]    result_o;
    logic [WB-1:0] bkt_bin_o;
    logic [WL-1:0] bkt_lvl_o;
    logic [WC-1:0] num_decisions_o, num_conflicts_o;

    sat_engine_ctrl #(
        .WIDTH_LVL(WL), .WIDTH_BIN_ID(WB), .WIDTH_CNT(WC), .WIDTH_TO(WT), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .cur_bin_num_i(cur_bin_num_i),
        .cur_lvl_i(cur_lvl_i), .all_assigned_i(all_assigned_i),
        .start_decision_o(start_decision_o), .done_decision_i(done_decision_i),
        .apply_imply_o(apply_imply_o), .done_imply_i(done_imply_i),
        .find_conflict_i(find_conflict_i), .apply_analyze_o(apply_analyze_o),
        .done_analyze_i(done_analyze_i), .bkt_bin_i(bkt_bin_i), .bkt_lvl_i(bkt_lvl_i),
        .apply_bkt_cur_bin_o(apply_bkt_cur_bin_o), .done_bkt_cur_bin_i(done_bkt_cur_bin_i),
        .done_o(done_o), .result_o(result_o), .timeout_o(timeout_o),
        .bkt_bin_o(bkt_bin_o), .bkt_lvl_o(bkt_lvl_o), .busy_o(busy_o),
        .num_decisions_o(num_decisions_o), .num_conflicts_o(num_conflicts_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int mon_dec = 0;
    int mon_ana = 0;
    int mon_bkt = 0;
    step_t script[$];

    // Strobe pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (start_decision_o)    mon_dec++;
        if (apply_analyze_o)     mon_ana++;
        if (apply_bkt_cur_bin_o) mon_bkt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {start_decision_o, apply_imply_o, apply_analyze_o,
                              apply_bkt_cur_bin_o, done_o, result_o, timeout_o, busy_o,
                              num_decisions_o, num_conflicts_o}, 64'd0);
        check({tag, "_bkt"}, {bkt_bin_o, bkt_lvl_o}, 64'd0);
    endtask

    task automatic clr_in();
        done_decision_i    = 1'b0;
        done_imply_i       = 1'b0;
        find_conflict_i    = 1'b0;
        all_assigned_i     = 1'b0;
        done_analyze_i     = 1'b0;
        done_bkt_cur_bin_i = 1'b0;
        bkt_bin_i          = '0;
        bkt_lvl_i          = '0;
    endtask

    function automatic step_t mk(input int kind, input int bin);
        step_t s;
        s.kind  = kind;
        s.idle  = int'($urandom_range(0, 3));
        s.lat1  = int'($urandom_range(1, 3));
        s.lat2  = int'($urandom_range(1, 3));
        s.lvl   = int'($urandom_range(1, 20));
        s.bbin  = (bin + 1 + int'($urandom_range(0, 1000))) % 1024;
        s.blvl  = int'($urandom_range(0, 65535));
        s.noise = 1'($urandom_range(0, 1));
        return s;
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Runs one solve of bin `bin` following `script`; the last step is terminal.
    task automatic run_solve(input string name, input int bin);
        step_t s;
        int e_dec, e_conf, e_loc, e_bout, e_res, e_to, e_bbin, e_blvl;
        int d0, a0, b0;
        e_dec = 0; e_conf = 0; e_loc = 0; e_bout = 0; e_res = 0; e_to = 0;
        e_bbin = 0; e_blvl = 0;
        @(negedge clk);
        d0 = mon_dec; a0 = mon_ana; b0 = mon_bkt;
        cur_bin_num_i = WB'(bin);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check({name, "_start_imply"}, {busy_o, apply_imply_o}, 2'b11);
        check({name, "_start_clear"}, {result_o, timeout_o, num_decisions_o, num_conflicts_o}, 0);
        foreach (script[i]) begin
            s = script[i];
            repeat (s.idle) @(negedge clk);
            case (s.kind)
                K_DEC, K_TMO: begin
                    done_imply_i = 1'b1;
                    done_bkt_cur_bin_i = s.noise;
                    @(negedge clk);
                    clr_in();
                    check({name, "_dec_strobe"}, start_decision_o, 1);
                    e_dec++;
                    if (s.kind == K_TMO) begin
                        repeat (TO) @(negedge clk);
                        check({name, "_wd_early"}, done_o, 0);
                        @(negedge clk);
                        check({name, "_wd_done"}, done_o, 1);
                        e_to = 1;
                    end else begin
                        repeat (s.lat1) @(negedge clk);
                        if (s.noise) begin
                            start_i = 1'b1;
                            @(negedge clk);
                            start_i = 1'b0;
                            check({name, "_busy_start"}, {busy_o, apply_imply_o, start_decision_o}, 3'b100);
                        end
                        done_decision_i = 1'b1;
                        @(negedge clk);
                        clr_in();
                        check({name, "_dec_back"}, apply_imply_o, 1);
                    end
                end
                K_LOC, K_BOUT: begin
                    cur_lvl_i = WL'(s.lvl);
                    find_conflict_i = 1'b1;
                    done_imply_i = s.noise;
                    all_assigned_i = s.noise;
                    @(negedge clk);
                    clr_in();
                    check({name, "_ana_strobe"}, {apply_analyze_o, done_o}, 2'b10);
                    e_conf++;
                    repeat (s.lat1) @(negedge clk);
                    done_analyze_i = 1'b1;
                    bkt_bin_i = (s.kind == K_LOC) ? WB'(bin) : WB'(s.bbin);
                    bkt_lvl_i = WL'(s.blvl);
                    @(negedge clk);
                    clr_in();
                    if (s.kind == K_LOC) begin
                        check({name, "_bkt_strobe"}, apply_bkt_cur_bin_o, 1);
                        e_loc++;
                        repeat (s.lat2) @(negedge clk);
                        done_bkt_cur_bin_i = 1'b1;
                        @(negedge clk);
                        clr_in();
                        check({name, "_bkt_back"}, apply_imply_o, 1);
                    end else begin
                        check({name, "_bout_done"}, done_o, 1);
                        e_bout++;
                        e_res = 3;
                        e_bbin = s.bbin;
                        e_blvl = s.blvl;
                    end
                end
                K_SAT: begin
                    done_imply_i = 1'b1;
                    all_assigned_i = 1'b1;
                    @(negedge clk);
                    clr_in();
                    check({name, "_sat_done"}, done_o, 1);
                    e_res = 1;
                end
                default: begin
                    cur_lvl_i = '0;
                    find_conflict_i = 1'b1;
                    done_imply_i = s.noise;
                    all_assigned_i = s.noise;
                    @(negedge clk);
                    clr_in();
                    check({name, "_unsat_done"}, {done_o, apply_analyze_o}, 2'b10);
                    e_conf++;
                    e_res = 2;
                end
            endcase
        end
        check({name, "_result"}, result_o, e_res);
        check({name, "_timeout"}, timeout_o, e_to);
        check({name, "_ndec"}, num_decisions_o, sat(e_dec));
        check({name, "_nconf"}, num_conflicts_o, sat(e_conf));
        if (e_res == 3) check({name, "_bkt_out"}, {bkt_bin_o, bkt_lvl_o}, {WB'(e_bbin), WL'(e_blvl)});
        @(negedge clk);
        check({name, "_idle"}, {done_o, busy_o, result_o}, {2'b00, 2'(e_res)});
        check({name, "_pulses"}, {mon_dec - d0, mon_ana - a0, mon_bkt - b0},
              {e_dec, e_loc + e_bout, e_loc});
        $display("solve %s bin=%0d: result=%0d timeout=%0d dec=%0d conf=%0d", name, bin,
                 result_o, timeout_o, num_decisions_o, num_conflicts_o);
    endtask

    initial begin
        step_t s;
        int nsteps;
        #1 rst = 1'b1;
        #1 check_all_zero("reset_async");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset_idle");

        // SAT path: one decision with responder latency 2.
        script.delete();
        s = mk(K_DEC, 5); s.idle = 0; s.lat1 = 2; s.noise = 0; script.push_back(s);
        s = mk(K_SAT, 5); script.push_back(s);
        run_solve("sat_path", 5);

        script.delete();
        s = mk(K_UNSAT, 5); s.noise = 0; script.push_back(s);
        run_solve("lvl0_conf", 5);

        script.delete();
        s = mk(K_LOC, 5); s.lvl = 3; s.blvl = 1; s.noise = 0; script.push_back(s);
        s = mk(K_SAT, 5); script.push_back(s);
        run_solve("local_bkt", 5);

        script.delete();
        s = mk(K_BOUT, 5); s.lvl = 3; s.bbin = 2; s.blvl = 7; s.noise = 1; script.push_back(s);
        run_solve("bin_exit", 5);

        script.delete();
        s = mk(K_TMO, 5); s.noise = 0; script.push_back(s);
        run_solve("watchdog", 5);

        script.delete();
        s = mk(K_DEC, 9); s.noise = 1; script.push_back(s);
        s = mk(K_SAT, 9); script.push_back(s);
        run_solve("busy_start", 9);

        // Counters saturate at all-ones.
        script.delete();
        for (int i = 0; i < 9; i++) script.push_back(mk(K_DEC, 3));
        for (int i = 0; i < 9; i++) script.push_back(mk(K_LOC, 3));
        script.push_back(mk(K_UNSAT, 3));
        run_solve("saturate", 3);

        for (int r = 0; r < 25; r++) begin
            int bin;
            bin = int'($urandom_range(0, 1023));
            script.delete();
            nsteps = int'($urandom_range(0, 10));
            for (int i = 0; i < nsteps; i++)
                script.push_back(mk(($urandom_range(0, 1) == 0) ? K_DEC : K_LOC, bin));
            script.push_back(mk(int'($urandom_range(K_SAT, K_TMO)), bin));
            run_solve($sformatf("rand%0d", r), bin);
        end

        // Async reset in WAIT_ANA after a bin exit left bkt_* nonzero.
        script.delete();
        s = mk(K_BOUT, 4); s.bbin = 6; s.blvl = 11; script.push_back(s);
        run_solve("pre_reset", 4);
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cur_lvl_i = WL'(3);
        find_conflict_i = 1'b1;
        @(negedge clk);
        clr_in();
        check("rst_ana_strobe", apply_analyze_o, 1);
        @(negedge clk);
        check("rst_in_wait_ana", {busy_o, num_conflicts_o}, {1'b1, 3'd1});
        #2 rst = 1'b1;
        #1 check_all_zero("reset_mid_solve");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset_release");

        script.delete();
        script.push_back(mk(K_DEC, 7));
        script.push_back(mk(K_SAT, 7));
        run_solve("post_reset", 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/sat_engine_ctrl.md
# sat_engine_ctrl

Top-level sequencer of one sat engine. It drives the state-list command strobes (decision, implication, conflict analysis, current-bin backtrack) and consumes their done flags. It ends each bin solve with a SAT, UNSAT, backtrack-out-of-bin or timeout result for the bin manager. It also keeps per-bin decision and conflict statistics.

## Interface
Parameters:
- WIDTH_LVL, 16, level width
- WIDTH_BIN_ID, 10, bin id width
- WIDTH_CNT, 16, statistic counter width
- WIDTH_TO, 8, watchdog counter width
- TIMEOUT, 200, max cycles spent in one waiting state

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset; asynchronous, active-high
- start_i  in  1  pulse: bin loaded, begin solving
- cur_bin_num_i  in  WIDTH_BIN_ID  id of bin being solved
- cur_lvl_i  in  WIDTH_LVL  current absolute decision level
- all_assigned_i  in  1  every variable of bin has a value
- start_decision_o  out  1  one-cycle decision strobe
- done_decision_i  in  1  decision finished
- apply_imply_o  out  1  level: run BCP
- done_imply_i  in  1  BCP reached fixpoint
- find_conflict_i  in  1  conflict present
- apply_analyze_o  out  1  one-cycle analysis strobe
- done_analyze_i  in  1  analysis finished; bkt_* valid this cycle
- bkt_bin_i  in  WIDTH_BIN_ID  target bin of backtrack
- bkt_lvl_i  in  WIDTH_LVL  target level of backtrack
- apply_bkt_cur_bin_o  out  1  one-cycle local-backtrack strobe
- done_bkt_cur_bin_i  in  1  local backtrack finished
- done_o  out  1  one-cycle pulse: result valid
- result_o  out  2  0 none, 1 SAT, 2 UNSAT, 3 BKT_OUT
- timeout_o  out  1  solve aborted by watchdog
- bkt_bin_o  out  WIDTH_BIN_ID  latched bkt_bin_i (BKT_OUT)
- bkt_lvl_o  out  WIDTH_LVL  latched bkt_lvl_i (BKT_OUT)
- busy_o  out  1  state != IDLE
- num_decisions_o  out  WIDTH_CNT  decisions this solve
- num_conflicts_o  out  WIDTH_CNT  conflicts this solve

## Operation
- States: IDLE, IMPLY, DECIDE, WAIT_DEC, ANALYZE, WAIT_ANA, BKT, WAIT_BKT, FINISH.
- IDLE: start_i moves to IMPLY. The same edge:
  - clears both counters, timeout_o and result_o;
  - clears the watchdog counter.
- IMPLY: apply_imply_o = 1 throughout. Evaluate in priority order:
  1. find_conflict_i with cur_lvl_i == 0 → FINISH, result UNSAT, num_conflicts_o +1.
  2. find_conflict_i → ANALYZE, num_conflicts_o +1.
  3. done_imply_i with all_assigned_i → FINISH, result SAT.
  4. done_imply_i → DECIDE.
  5. Otherwise stay.
- DECIDE: start_decision_o = 1 for exactly one cycle; num_decisions_o +1; → WAIT_DEC.
- WAIT_DEC: done_decision_i → IMPLY.
- ANALYZE: apply_analyze_o = 1 for one cycle; → WAIT_ANA.
- WAIT_ANA: on done_analyze_i, latch bkt_bin_i and bkt_lvl_i into bkt_bin_o and bkt_lvl_o, then:
  - bkt_bin_i != cur_bin_num_i → FINISH, result BKT_OUT;
  - otherwise → BKT.
- BKT: apply_bkt_cur_bin_o = 1 for one cycle; → WAIT_BKT.
- WAIT_BKT: done_bkt_cur_bin_i → IMPLY.
- FINISH: done_o = 1 for one cycle; → IDLE.
- result_o, timeout_o, bkt_bin_o and bkt_lvl_o hold until the next accepted start_i.
- Watchdog:
  - clears on every state change;
  - increments each cycle in IMPLY, WAIT_DEC, WAIT_ANA, WAIT_BKT;
  - reaching TIMEOUT → FINISH with timeout_o = 1 and result_o = 0.
- Counters saturate at all-ones; they never wrap.
- start_i is ignored outside IDLE.
- done_* inputs arriving in a state that does not wait for them are ignored.

## Timing
- Reset (async, any time, including mid-solve):
  - state → IDLE;
  - all outputs 0: done_o, result_o, timeout_o, bkt_bin_o, bkt_lvl_o, busy_o, counters, all strobes.
- All outputs are registered or decoded from the state register only; no input→output combinational path.
- start_i sampled at edge N → apply_imply_o and busy_o high from N+1.
- A done/condition sampled at edge M → next state's strobe is high during cycle M+1.
- Minimal decision round trip: IMPLY exit edge → DECIDE cycle → WAIT_DEC → IMPLY; 1 strobe cycle plus the responder's latency.
- done_o asserts one cycle after the deciding edge; result_o is valid in the same cycle as done_o and afterwards.
- find_conflict_i and done_imply_i together in IMPLY: conflict wins.

## Test plan
- SAT path: start_i; done_imply_i = 1 with all_assigned_i = 0, then done_decision_i after 2 cycles, then done_imply_i with all_assigned_i = 1 → exactly one start_decision_o pulse; done_o with result_o = 1; num_decisions_o = 1.
- Level-0 conflict: start_i, find_conflict_i = 1, cur_lvl_i = 0 → no apply_analyze_o; done_o, result_o = 2, num_conflicts_o = 1.
- Local backtrack: conflict at cur_lvl_i = 3; done_analyze_i with bkt_bin_i = cur_bin_num_i = 5, bkt_lvl_i = 1 → one apply_bkt_cur_bin_o pulse; after done_bkt_cur_bin_i, apply_imply_o = 1 again.
- Bin exit: done_analyze_i with bkt_bin_i = 2, cur_bin_num_i = 5, bkt_lvl_i = 7 → result_o = 3, bkt_bin_o = 2, bkt_lvl_o = 7, no apply_bkt_cur_bin_o.
- Watchdog: TIMEOUT = 10; hold done_decision_i = 0 in WAIT_DEC → done_o 10 cycles after entry, timeout_o = 1, result_o = 0.
- Async reset mid-WAIT_ANA, plus start_i while busy: all outputs 0 immediately on reset, without waiting for a clock edge; a start_i pulsed while in WAIT_DEC changes nothing.
